blinker_counter: RTL and testbench

Blink-enable generator. While `blink` is asserted it drives `b_en` with a repeating pattern: high for `C_ON` clock cycles, then low for `C_OFF` clock cycles. While `blink` is deasserted, `b_en` is held low. It sits between control logic and any output, such as a display digit or an LED, that must flash at a parameterised duty cycle.

---
 rtl/blinker_counter_pkg.sv | 17 +
 rtl/blinker_phase_timer.sv | 24 ++
 rtl/blinker_counter.sv | 81 ++++++++
 tb/tb_blinker_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/blinker_counter_pkg.sv
// Shared types and sizing helpers for the blink-enable generator.
package blinker_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Minimum phase-counter width; never less than one bit so 1/1 patterns still build.
    function automatic int min_cnt_bits(input int c_on, input int c_off);
        int longest;
        longest = (c_on > c_off) ? c_on : c_off;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/blinker_phase_timer.sv
// Phase counter shared by ON and OFF: counts up from 0, flags the terminal count.
module blinker_phase_timer #(
    parameter int C_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [C_BITS-1:0] term,
    output logic              done
);

    logic [C_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == term);

endmodule

// File: rtl/blinker_counter.sv
// Blink-enable generator: b_en high for C_ON cycles, low for C_OFF, while blink is held.
// Optional b_cycle pulse on OFF->ON is built when BLINKER_COUNTER_CYCLE_PULSE_EN is defined.
//
// state | meaning
// IDLE  | blink low or just reset; b_en = 0
// ON    | ON phase in progress; b_en = 1
// OFF   | OFF phase in progress; b_en = 0
module blinker_counter
    import blinker_counter_pkg::*;
#(
    parameter int C_ON   = 3,
    parameter int C_OFF  = 2,
    parameter int C_BITS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic blink,
`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
    output logic b_cycle,
`endif
    output logic b_en
);

    if (C_ON < 1 || C_OFF < 1 || C_BITS < min_cnt_bits(C_ON, C_OFF)) begin : g_bad_cfg
        $error("blinker_counter: illegal C_ON/C_OFF/C_BITS combination");
    end

    localparam logic [C_BITS-1:0] ON_TC  = C_BITS'(C_ON - 1);
    localparam logic [C_BITS-1:0] OFF_TC = C_BITS'(C_OFF - 1);

    blink_state_t      state, state_next;
    logic              phase_done;
    logic              timer_load;
    logic [C_BITS-1:0] term;

    assign term       = (state == OFF) ? OFF_TC : ON_TC;
    assign timer_load = !blink || (state == IDLE) || phase_done;

    blinker_phase_timer #(
        .C_BITS(C_BITS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .term  (term),
        .done  (phase_done)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = ON;
            ON:      if (phase_done) state_next = OFF;
            OFF:     if (phase_done) state_next = ON;
            default: state_next = IDLE;
        endcase
        // Dropping blink aborts any phase; the next request restarts with a full ON.
        if (!blink) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            b_en  <= 1'b0;
        end else begin
            state <= state_next;
            b_en  <= (state_next == ON);
        end
    end

`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            b_cycle <= 1'b0;
        end else begin
            b_cycle <= (state == OFF) && (state_next == ON);
        end
    end
`endif

endmodule

// File: tb/tb_blinker_counter.sv
// Directed, table-driven bench for blinker_counter (default 3/2/2 plus a 1/1 instance).
module tb_blinker_counter;

    typedef struct {
        logic  rst;
        logic  blk;
        logic  exp_en;
        logic  exp_cyc;
        string name;
    } vec_t;

    logic clk;
    logic reset;
    logic blink;
    logic b_en;
    logic b_cycle;
    logic blink_t;
    logic b_en_t;
    logic b_cycle_t;

    int checks;
    int errors;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    blinker_counter #(.C_ON(3), .C_OFF(2), .C_BITS(2)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .blink   (blink),
`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
        .b_cycle (b_cycle),
`endif
        .b_en    (b_en)
    );

    blinker_counter #(.C_ON(1), .C_OFF(1), .C_BITS(1)) u_dut_t (
        .clk     (clk),
        .reset   (reset),
        .blink   (blink_t),
`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
        .b_cycle (b_cycle_t),
`endif
        .b_en    (b_en_t)
    );

`ifndef BLINKER_COUNTER_CYCLE_PULSE_EN
    assign b_cycle   = 1'b0;
    assign b_cycle_t = 1'b0;
`endif

    task automatic add(input logic r, input logic b, input logic e, input logic c, input string n);
        vec_t v;
        v.rst = r; v.blk = b; v.exp_en = e; v.exp_cyc = c; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check_bit(input string n, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %b expected %b", n, idx, act, exp);
        end
    endtask

    initial begin
        logic [5:0] exp_t;
        logic [5:0] exp_tc;

        reset   = 1'b1;
        blink   = 1'b0;
        blink_t = 1'b0;
        checks  = 0;
        errors  = 0;

        add(1, 1'bx, 0, 0, "reset");
        // 11 cycles of blink: pattern 1,1,1,0,0 repeating, pulses after each OFF->ON
        add(0, 1, 1, 0, "run"); add(0, 1, 1, 0, "run"); add(0, 1, 1, 0, "run");
        add(0, 1, 0, 0, "run"); add(0, 1, 0, 0, "run"); add(0, 1, 1, 1, "run");
        add(0, 1, 1, 0, "run"); add(0, 1, 1, 0, "run"); add(0, 1, 0, 0, "run");
        add(0, 1, 0, 0, "run"); add(0, 1, 1, 1, "run");
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, "stop");
        // abort mid-ON then full restart
        add(0, 1, 1, 0, "abort_on"); add(0, 1, 1, 0, "abort_on"); add(0, 0, 0, 0, "abort_on");
        add(0, 1, 1, 0, "restart"); add(0, 1, 1, 0, "restart"); add(0, 1, 1, 0, "restart");
        add(0, 1, 0, 0, "restart"); add(0, 1, 0, 0, "restart");
        // abort on the final OFF cycle: no pulse
        add(0, 0, 0, 0, "abort_off");
        // reset mid-OFF with blink held
        add(0, 1, 1, 0, "pre_rst"); add(0, 1, 1, 0, "pre_rst"); add(0, 1, 1, 0, "pre_rst");
        add(0, 1, 0, 0, "pre_rst");
        add(1, 1, 0, 0, "rst_prio"); add(1, 1, 0, 0, "rst_prio");
        add(0, 1, 1, 0, "post_rst"); add(0, 1, 1, 0, "post_rst"); add(0, 1, 1, 0, "post_rst");
        add(0, 1, 0, 0, "post_rst"); add(0, 1, 0, 0, "post_rst"); add(0, 1, 1, 1, "post_rst");
        add(0, 0, 0, 0, "idle");
        // toggling blink every cycle: b_en follows one cycle later
        for (int i = 0; i < 6; i++) add(0, i[0] ? 1'b0 : 1'b1, i[0] ? 1'b0 : 1'b1, 0, "toggle");
        add(0, 0, 0, 0, "idle");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            blink = vecs[i].blk;
            @(posedge clk);
            #1;
            check_bit({vecs[i].name, "_b_en"}, i, b_en, vecs[i].exp_en);
`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
            check_bit({vecs[i].name, "_b_cycle"}, i, b_cycle, vecs[i].exp_cyc);
`endif
            @(negedge clk);
        end

        // 1/1 configuration toggles every cycle while blink is held
        exp_t  = 6'b010101;
        exp_tc = 6'b010100;
        reset   = 1'b0;
        blink_t = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_bit("c11_b_en", i, b_en_t, exp_t[i]);
`ifdef BLINKER_COUNTER_CYCLE_PULSE_EN
            check_bit("c11_b_cycle", i, b_cycle_t, exp_tc[i]);
`endif
            @(negedge clk);
        end
        blink_t = 1'b0;
        @(posedge clk);
        #1;
        check_bit("c11_stop", 0, b_en_t, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
